branch_predictor: RTL and testbench

//  Parametrised BTB + saturating-counter branch predictor for the 5-stage MIPS pipeline.

---
 rtl/bp_types_pkg.sv | 37 +++
 rtl/sat_counter.sv | 44 ++++
 rtl/branch_predictor.sv | 119 +++++++++++
 tb/tb_branch_predictor.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bp_types_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bp_types_pkg
// Purpose : Shared types and helpers for the BTB branch predictor.
//           btb_entry_t keeps the tag right-justified in a 32-bit field so the
//           same struct serves any ENTRIES value; unused upper tag bits are
//           always zero and fold away in synthesis.
// Revision: 1.0 - initial release
// ============================================================================
package bp_types_pkg;

  // Default geometry; the predictor derives its own IDX_W/TAG_W from ENTRIES.
  localparam int ENTRIES_DEF = 16;
  localparam int IDX_W       = $clog2(ENTRIES_DEF);
  localparam int TAG_W       = 32 - IDX_W - 2;
  localparam int CNT_W_DEF   = 2;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  // Word index into the BTB: pc[idx_w+1:2]
  function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
    bp_idx = (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: pc[31:idx_w+2], right-justified
  function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w);
    bp_tag = pc >> (idx_w + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up/down counter that saturates at 0 and all-ones, with a
//           synchronous load. Used for BTB direction counters and perf counters.
// Ports   : CLK, nRST (async, active low) ; inc/dec step ; load/init preset ;
//           q current value.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W       = 2,
  parameter int RST_VAL = 0
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] init,
  output logic [W-1:0] q
);
  import bp_types_pkg::*;

  localparam logic [W-1:0] c_max = '1;

  logic [W-1:0] r_q;

  // load takes priority; simultaneous inc and dec cancel out
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_q <= W'(RST_VAL);
    end else if (load) begin
      r_q <= init;
    end else if (inc && !dec && (r_q != c_max)) begin
      r_q <= r_q + W'(1);
    end else if (dec && !inc && (r_q != '0)) begin
      r_q <= r_q - W'(1);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor
// Purpose : Direct-mapped BTB with per-entry saturating direction counters.
//           Combinational lookup for IF, combinational mispredict check for the
//           resolving stage, clocked update, and saturating perf counters.
// Ports   : CLK, nRST (async, active low)
//           lookup_pc -> pred_taken, pred_npc
//           upd_valid/upd_pc/upd_taken/upd_target/upd_pred_taken/upd_pred_npc
//             -> mispredict, correct_npc
//           flush_all : synchronous invalidate of all entries
//           branch_cnt, mispred_cnt : perf counters
// Revision: 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_types_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = 1,
  parameter int PERF_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       lookup_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_npc,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_npc,
  output logic              mispredict,
  output logic [31:0]       correct_npc,
  input  logic              flush_all,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);

  localparam int BP_IDX_W = $clog2(ENTRIES);
  localparam int c_cnt_max   = (1 << CNT_W) - 1;
  localparam int c_alloc_int = (CNT_INIT + 1 > c_cnt_max) ? c_cnt_max : CNT_INIT + 1;
  localparam logic [CNT_W-1:0] c_alloc = CNT_W'(c_alloc_int);

  btb_entry_t          r_btb [ENTRIES];
  logic [CNT_W-1:0]    w_cnt [ENTRIES];

  logic [BP_IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [31:0]         w_lk_tag, w_up_tag;
  logic                w_lk_hit, w_upd_hit, w_upd_en;

  assign w_lk_idx = BP_IDX_W'(bp_idx(lookup_pc, BP_IDX_W));
  assign w_lk_tag = bp_tag(lookup_pc, BP_IDX_W);
  assign w_up_idx = BP_IDX_W'(bp_idx(upd_pc, BP_IDX_W));
  assign w_up_tag = bp_tag(upd_pc, BP_IDX_W);

  // Lookup sees pre-update state; no bypass from the update port.
  assign w_lk_hit   = r_btb[w_lk_idx].valid && (r_btb[w_lk_idx].tag == w_lk_tag);
  assign pred_taken = w_lk_hit && w_cnt[w_lk_idx][CNT_W-1];
  assign pred_npc   = pred_taken ? r_btb[w_lk_idx].target : lookup_pc + 32'd4;

  assign w_upd_hit   = r_btb[w_up_idx].valid && (r_btb[w_up_idx].tag == w_up_tag);
  assign correct_npc = upd_taken ? upd_target : upd_pc + 32'd4;
  // Compare full NPC so a wrong target with the right direction also flushes.
  // upd_pred_taken is implied by upd_pred_npc and needs no separate check.
  assign mispredict  = upd_valid && (upd_pred_npc != correct_npc);

  // Flush takes precedence over any entry change in the same cycle.
  assign w_upd_en = upd_valid && !flush_all;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) r_btb[i] <= '0;
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) r_btb[i].valid <= 1'b0;
    end else if (upd_valid && upd_taken) begin
      // Hit refreshes the target; miss allocates. Writing valid/tag on a hit
      // rewrites identical values, so both cases share one assignment.
      r_btb[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: upd_target};
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    logic w_sel;
    assign w_sel = w_upd_en && (w_up_idx == BP_IDX_W'(i));
    sat_counter #(.W(CNT_W), .RST_VAL(CNT_INIT)) u_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (w_sel && w_upd_hit && upd_taken),
      .dec  (w_sel && w_upd_hit && !upd_taken),
      .load (w_sel && !w_upd_hit && upd_taken),
      .init (c_alloc),
      .q    (w_cnt[i])
    );
  end

  sat_counter #(.W(PERF_W), .RST_VAL(0)) u_branch_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (upd_valid),
    .dec  (1'b0),
    .load (1'b0),
    .init ('0),
    .q    (branch_cnt)
  );

  sat_counter #(.W(PERF_W), .RST_VAL(0)) u_mispred_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (mispredict),
    .dec  (1'b0),
    .load (1'b0),
    .init ('0),
    .q    (mispred_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_branch_predictor
// Purpose : Scoreboard bench: a driver issues one directed vector per cycle and
//           queues its expected response; a monitor pops and compares on the
//           falling edge. A second instance with PERF_W=4 shares the stimulus
//           to exercise perf-counter saturation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] lookup_pc = '0, upd_pc = '0, upd_target = '0, upd_pred_npc = '0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0, flush_all = 1'b0;

  logic        pred_taken, mispredict;
  logic [31:0] pred_npc, correct_npc, branch_cnt, mispred_cnt;
  logic        pt4, mis4;
  logic [31:0] pn4, cn4;
  logic [3:0]  bc4, mc4;

  always #5 CLK = ~CLK;

  branch_predictor dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_taken(pred_taken), .pred_npc(pred_npc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc), .mispredict(mispredict),
    .correct_npc(correct_npc), .flush_all(flush_all), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predictor #(.PERF_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_taken(pt4), .pred_npc(pn4),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc), .mispredict(mis4),
    .correct_npc(cn4), .flush_all(flush_all), .branch_cnt(bc4), .mispred_cnt(mc4)
  );

  typedef struct {
    string       name;
    bit          cp;  bit ep;  logic [31:0] enpc;
    bit          cm;  bit em;  logic [31:0] ecn;
    bit          cc;  logic [31:0] ebc; logic [31:0] emc;
    bit          c4;  logic [3:0] e4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle
  exp_t m;
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      if (m.cp) begin
        chk({m.name, " pred_taken"}, {31'b0, pred_taken}, {31'b0, m.ep});
        chk({m.name, " pred_npc"}, pred_npc, m.enpc);
      end
      if (m.cm) begin
        chk({m.name, " mispredict"}, {31'b0, mispredict}, {31'b0, m.em});
        chk({m.name, " correct_npc"}, correct_npc, m.ecn);
      end
      if (m.cc) begin
        chk({m.name, " branch_cnt"}, branch_cnt, m.ebc);
        chk({m.name, " mispred_cnt"}, mispred_cnt, m.emc);
      end
      if (m.c4) chk({m.name, " branch_cnt4"}, {28'b0, bc4}, {28'b0, m.e4});
    end
  end

  task automatic step(
    input string nm, input bit rstn, input logic [31:0] lk,
    input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
    input logic [31:0] upnpc, input bit fl,
    input bit cp, input bit ep, input logic [31:0] enpc,
    input bit cm, input bit em, input logic [31:0] ecn,
    input bit cc, input logic [31:0] ebc, input logic [31:0] emc,
    input bit c4, input logic [3:0] e4);
    exp_t e;
    @(posedge CLK); #1;
    nRST = rstn; lookup_pc = lk; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_npc = upnpc; upd_pred_taken = (upnpc != upc + 32'd4);
    flush_all = fl;
    e.name = nm; e.cp = cp; e.ep = ep; e.enpc = enpc; e.cm = cm; e.em = em; e.ecn = ecn;
    e.cc = cc; e.ebc = ebc; e.emc = emc; e.c4 = c4; e.e4 = e4;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  initial begin
    logic [31:0] pc;
    // Reset state and 32-bit wrap of PC+4
    step("reset", 0, 32'h40, 0,0,0,0,0,0, 1,0,32'h44, 1,0,32'h4, 1,0,0, 1,0);
    step("wrap",  0, 32'hFFFF_FFFC, 0,0,0,0,0,0, 1,0,32'h0, 0,0,0, 0,0,0, 0,0);
    // First taken branch allocates; lookup same cycle still misses
    step("alloc", 1, 32'h100, 1,32'h100,1,32'h80,32'h104,0, 1,0,32'h104, 1,1,32'h80, 1,0,0, 1,0);
    step("hit",   1, 32'h100, 0,0,0,0,0,0, 1,1,32'h80, 0,0,0, 1,1,1, 1,1);
    for (int k = 0; k < 3; k++)
      step("taken", 1, 32'h100, 1,32'h100,1,32'h80,32'h80,0, 1,1,32'h80, 1,0,32'h80, 1,1+k,1, 1,4'(1+k));
    // cnt 3 -> 2 still taken, then 2 -> 1 not taken
    step("nt1",  1, 32'h100, 1,32'h100,0,32'h80,32'h80,0, 1,1,32'h80, 1,1,32'h104, 1,4,1, 1,4);
    step("nt2",  1, 32'h100, 1,32'h100,0,32'h80,32'h80,0, 1,1,32'h80, 1,1,32'h104, 1,5,2, 1,5);
    step("weak", 1, 32'h100, 0,0,0,0,0,0, 1,0,32'h104, 0,0,0, 1,6,3, 1,6);
    // Aliasing on index 0
    step("alias",     1, 32'h140, 1,32'h140,1,32'h300,32'h144,0, 1,0,32'h144, 1,1,32'h300, 1,6,3, 1,6);
    step("alias_old", 1, 32'h100, 0,0,0,0,0,0, 1,0,32'h104, 0,0,0, 1,7,4, 1,7);
    step("alias_new", 1, 32'h140, 0,0,0,0,0,0, 1,1,32'h300, 0,0,0, 1,7,4, 1,7);
    // Same-cycle lookup/update, then flush racing an allocation
    step("same_cyc",  1, 32'h200, 1,32'h200,1,32'h400,32'h204,0, 1,0,32'h204, 1,1,32'h400, 1,7,4, 1,7);
    step("flush_upd", 1, 32'h200, 1,32'h180,1,32'h500,32'h184,1, 1,1,32'h400, 1,1,32'h500, 1,8,5, 1,8);
    step("flushed",   1, 32'h180, 0,0,0,0,0,0, 1,0,32'h184, 0,0,0, 1,9,6, 1,9);
    step("flushed2",  1, 32'h200, 0,0,0,0,0,0, 1,0,32'h204, 0,0,0, 1,9,6, 1,9);
    // Fill every entry
    for (int i = 0; i < 16; i++) begin
      pc = 32'h1000 + 32'(4*i);
      step("fill", 1, pc, 1,pc,1,32'h2000 + 32'(4*i),pc + 32'd4,0, 1,0,pc + 32'd4,
           1,1,32'h2000 + 32'(4*i), 1,32'(9+i),32'(6+i), 1,sat4(9+i));
    end
    step("full",    1, 32'h1014, 0,0,0,0,0,0, 1,1,32'h2014, 0,0,0, 1,25,22, 1,15);
    step("rst_mid", 0, 32'h1014, 0,0,0,0,0,0, 1,0,32'h1018, 0,0,0, 1,0,0, 1,0);
    for (int i = 0; i < 16; i++) begin
      pc = 32'h1000 + 32'(4*i);
      step("post_rst", 1, pc, 0,0,0,0,0,0, 1,0,pc + 32'd4, 0,0,0, 1,0,0, 1,0);
    end
    // Not-taken misses never allocate; 4-bit perf counter saturates at 0xF
    for (int i = 0; i < 20; i++)
      step("sat", 1, 32'h3000, 1,32'h3000,0,32'h0,32'h3004,0, 1,0,32'h3004, 1,0,32'h3004, 1,32'(i),0, 1,sat4(i));
    step("sat_end", 1, 32'h3000, 0,0,0,0,0,0, 1,0,32'h3004, 0,0,0, 1,20,0, 1,15);
    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge CLK);
    @(posedge CLK);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
